sigma7_sequencer: RTL and testbench

SIGMA7_SEQUENCER -- requirements
Module: sigma7_sequencer

---
 rtl/sigma7_sequencer_if.sv | 32 +++
 rtl/sigma7_sequencer.sv | 121 ++++++++++++
 tb/tb_sigma7_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sigma7_sequencer_if.sv
// Handshake and adder-tree bundle between the sigma7 sequencer and its environment.
// The master side supplies commands, products and the tree sum; the slave side is the sequencer.
interface sigma7_sequencer_if #(
    parameter int unsigned N  = 16,
    parameter int unsigned LW = 7
);
    logic          start;
    logic [LW-1:0] len;
    logic [N-1:0]  bias;
    logic          busy;

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;

    logic [N-1:0]  sum_a [0:6];
    logic [N-1:0]  sum_c;

    logic          res_valid;
    logic          res_ready;
    logic [N-1:0]  res_data;

    modport master (
        output start, len, bias, in_valid, in_data, sum_c, res_ready,
        input  busy, in_ready, sum_a, res_valid, res_data
    );

    modport slave (
        input  start, len, bias, in_valid, in_data, sum_c, res_ready,
        output busy, in_ready, sum_a, res_valid, res_data
    );
endinterface

// File: rtl/sigma7_sequencer.sv
// Feeds up to six products per pass plus the running accumulator into an external
// 7-input signed-magnitude adder tree, looping until the neuron's product count is consumed.
module sigma7_sequencer #(
    parameter int unsigned N       = 16,
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned LW      = $clog2(MAX_LEN + 1)
) (
    input logic              clk,
    input logic              rst_n,
    sigma7_sequencer_if.slave bus
);

    localparam int unsigned CW    = 3;
    localparam int unsigned SLOTS = 6;

    typedef enum logic [1:0] {IDLE, LOAD, SUM, OUT} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  acc_q;
    logic [LW-1:0] rem_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  slot_q [1:SLOTS];
    logic          busy_q, in_ready_q, res_valid_q;

    logic [LW-1:0] len_clamped_c;
    logic          beat_c;
    logic          enter_load_c;

    assign len_clamped_c = (bus.len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : bus.len;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        beat_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = (len_clamped_c != '0) ? LOAD : OUT;
            end
            LOAD: begin
                if (bus.in_valid && in_ready_q) begin
                    beat_c = 1'b1;
                    if (cnt_q == CW'(SLOTS - 1) || rem_q == LW'(1)) state_d = SUM;
                end
            end
            SUM: begin
                state_d = (rem_q == '0) ? OUT : LOAD;
            end
            OUT: begin
                if (res_valid_q && bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign enter_load_c = (state_d == LOAD) && (state_q != LOAD);

    // Handshake flags registered from the next state so they track the state exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            busy_q      <= (state_d != IDLE);
            in_ready_q  <= (state_d == LOAD);
            res_valid_q <= (state_d == OUT);
        end
    end

    // Accumulator, remaining count and slot datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            for (int i = 1; i <= SLOTS; i++) slot_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        acc_q <= bus.bias;
                        rem_q <= len_clamped_c;
                    end
                end
                LOAD: begin
                    if (beat_c) begin
                        for (int i = 1; i <= SLOTS; i++) begin
                            if (cnt_q == CW'(i - 1)) slot_q[i] <= bus.in_data;
                        end
                        cnt_q <= cnt_q + CW'(1);
                        rem_q <= rem_q - LW'(1);
                    end
                end
                SUM:     acc_q <= bus.sum_c;
                default: ;
            endcase
            // Empty slots must read as +0 so a short final pass adds nothing extra
            if (enter_load_c) begin
                cnt_q <= '0;
                for (int i = 1; i <= SLOTS; i++) slot_q[i] <= '0;
            end
        end
    end

    always_comb begin
        bus.sum_a[0] = acc_q;
        for (int i = 1; i <= SLOTS; i++) bus.sum_a[i] = slot_q[i];
    end

    assign bus.busy      = busy_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = acc_q;

endmodule

// File: tb/tb_sigma7_sequencer.sv
// Directed bench for sigma7_sequencer with a behavioural signed-magnitude adder tree.
module tb_sigma7_sequencer;

    localparam int unsigned N       = 16;
    localparam int unsigned MAX_LEN = 64;
    localparam int unsigned LW      = 7;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;
    int   tree_acc;

    always #5 clk = ~clk;

    sigma7_sequencer_if #(.N(N), .LW(LW)) bus ();

    sigma7_sequencer #(.N(N), .MAX_LEN(MAX_LEN), .LW(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic int sm_to_int(input logic [N-1:0] x);
        int m;
        m = int'(x[N-2:0]);
        return x[N-1] ? -m : m;
    endfunction

    function automatic logic [N-1:0] int_to_sm(input int v);
        if (v < 0) return {1'b1, 15'(-v)};
        return {1'b0, 15'(v)};
    endfunction

    // External sigma7 adder tree
    always_comb begin
        tree_acc = 0;
        for (int i = 0; i < 7; i++) tree_acc = tree_acc + sm_to_int(bus.sum_a[i]);
        bus.sum_c = int_to_sm(tree_acc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one neuron with a constant product value; returns counts observed at the ports
    task automatic feed(input logic [LW-1:0] ln, input logic [N-1:0] b, input logic [N-1:0] d,
                        input bit toggle, output int beats, output int sums, output int cycles);
        int pass_beats;
        bus.start = 1'b1;
        bus.len   = ln;
        bus.bias  = b;
        tick();
        bus.start  = 1'b0;
        cycles     = 1;
        beats      = 0;
        sums       = 0;
        pass_beats = 0;
        while (!bus.res_valid && cycles < 300) begin
            bus.in_valid = toggle ? ((cycles % 2) == 1) : 1'b1;
            bus.in_data  = d;
            if (bus.in_valid && bus.in_ready) beats++;
            if (bus.busy && !bus.in_ready && !bus.res_valid) begin
                sums++;
                for (int k = 1; k <= 6; k++) begin
                    if (k <= beats - pass_beats) check("slot_filled", 32'(bus.sum_a[k]), 32'(d));
                    else                         check("slot_empty", 32'(bus.sum_a[k]), 32'h0);
                end
                pass_beats = beats;
            end
            tick();
            cycles++;
        end
        bus.in_valid = 1'b0;
        check("res_valid_timeout", 32'(bus.res_valid), 32'h1);
    endtask

    task automatic handshake();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("idle_after_hs", 32'(bus.busy), 32'h0);
        check("no_valid_after_hs", 32'(bus.res_valid), 32'h0);
    endtask

    initial begin
        int beats, sums, cycles;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.bias      = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.res_ready = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h0);
        check("rst_res_valid", 32'(bus.res_valid), 32'h0);
        check("rst_res_data", 32'(bus.res_data), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Six products of +1.0 with bias +1.0
        feed(7'd6, 16'h0100, 16'h0100, 1'b0, beats, sums, cycles);
        check("t1_beats", 32'(beats), 32'd6);
        check("t1_sums", 32'(sums), 32'd1);
        check("t1_latency", 32'(cycles), 32'd8);
        check("t1_data", 32'(bus.res_data), 32'h0700);
        handshake();

        // Thirteen products, three passes, last pass one slot
        feed(7'd13, 16'h0000, 16'h0100, 1'b0, beats, sums, cycles);
        check("t2_beats", 32'(beats), 32'd13);
        check("t2_sums", 32'(sums), 32'd3);
        check("t2_latency", 32'(cycles), 32'd17);
        check("t2_data", 32'(bus.res_data), 32'h0D00);
        handshake();

        // Zero-length neuron returns the bias immediately
        feed(7'd0, 16'h8280, 16'h0100, 1'b0, beats, sums, cycles);
        check("t3_beats", 32'(beats), 32'd0);
        check("t3_latency", 32'(cycles), 32'd1);
        check("t3_in_ready", 32'(bus.in_ready), 32'h0);
        check("t3_data", 32'(bus.res_data), 32'h8280);
        handshake();

        // Mixed signs, stalled result, start pulse ignored in OUT
        bus.start = 1'b1;
        bus.len   = 7'd2;
        bus.bias  = 16'h0100;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h8200;
        tick();
        bus.in_data = 16'h0080;
        tick();
        bus.in_valid = 1'b0;
        check("t4_sum_in_ready", 32'(bus.in_ready), 32'h0);
        check("t4_slot1", 32'(bus.sum_a[1]), 32'h8200);
        check("t4_slot2", 32'(bus.sum_a[2]), 32'h0080);
        check("t4_slot3", 32'(bus.sum_a[3]), 32'h0000);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", 32'(bus.res_valid), 32'h1);
            check("t4_hold_data", 32'(bus.res_data), 32'h8080);
            bus.start = (i == 1);
            bus.len   = 7'd3;
            bus.bias  = 16'h1234;
            tick();
        end
        bus.start = 1'b0;
        check("t4_post_start_data", 32'(bus.res_data), 32'h8080);
        handshake();
        tick();
        check("t4_still_idle", 32'(bus.busy), 32'h0);

        // Reset mid-operation
        bus.start = 1'b1;
        bus.len   = 7'd6;
        bus.bias  = 16'h0100;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0100;
        tick();
        tick();
        tick();
        bus.in_valid = 1'b0;
        check("t5_pre_busy", 32'(bus.busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 32'(bus.busy), 32'h0);
        check("t5_rst_in_ready", 32'(bus.in_ready), 32'h0);
        check("t5_rst_res_valid", 32'(bus.res_valid), 32'h0);
        check("t5_rst_acc", 32'(bus.sum_a[0]), 32'h0);
        check("t5_rst_slot1", 32'(bus.sum_a[1]), 32'h0);
        check("t5_rst_slot3", 32'(bus.sum_a[3]), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        feed(7'd1, 16'h0000, 16'h0040, 1'b0, beats, sums, cycles);
        check("t5_latency", 32'(cycles), 32'd3);
        check("t5_data", 32'(bus.res_data), 32'h0040);
        handshake();

        // Seven products with in_valid toggling
        feed(7'd7, 16'h0100, 16'h0100, 1'b1, beats, sums, cycles);
        check("t6_beats", 32'(beats), 32'd7);
        check("t6_sums", 32'(sums), 32'd2);
        check("t6_latency", 32'(cycles), 32'd15);
        check("t6_data", 32'(bus.res_data), 32'h0800);
        handshake();

        // Length above MAX_LEN is clamped
        feed(7'd70, 16'h0000, 16'h0001, 1'b0, beats, sums, cycles);
        check("t7_beats", 32'(beats), 32'd64);
        check("t7_sums", 32'(sums), 32'd11);
        check("t7_latency", 32'(cycles), 32'd76);
        check("t7_data", 32'(bus.res_data), 32'h0040);
        handshake();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
